// File: rtl/muldiv_pkg.sv
// Shared opcode constants and FSM state encoding for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam logic OP_MUL    = 1'b0;
    localparam logic OP_DIV    = 1'b1;
    localparam int   OP_SIGNED = 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the datapath: shift-add multiply or restoring shift-subtract divide.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_op_div,
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_shreg,
    input  logic [WIDTH-1:0] i_operand,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_shreg
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_trial;
    logic [WIDTH:0] w_diff;

    // Single iteration; the restoring divide never needs the top trial bit once restored
    always_comb begin
        w_sum   = {1'b0, i_acc};
        w_trial = {i_acc, i_shreg[WIDTH-1]};
        w_diff  = w_trial - {1'b0, i_operand};
        o_acc   = i_acc;
        o_shreg = i_shreg;
        case (i_op_div)
            OP_MUL: begin
                if (i_shreg[0]) begin
                    w_sum = {1'b0, i_acc} + {1'b0, i_operand};
                end else begin
                    w_sum = {1'b0, i_acc};
                end
                o_acc   = w_sum[WIDTH:1];
                o_shreg = {w_sum[0], i_shreg[WIDTH-1:1]};
            end
            OP_DIV: begin
                if (!w_diff[WIDTH]) begin
                    o_acc   = w_diff[WIDTH-1:0];
                    o_shreg = {i_shreg[WIDTH-2:0], 1'b1};
                end else begin
                    o_acc   = w_trial[WIDTH-1:0];
                    o_shreg = {i_shreg[WIDTH-2:0], 1'b0};
                end
            end
            default: begin
                o_acc   = i_acc;
                o_shreg = i_shreg;
            end
        endcase
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle integer multiply/divide unit holding HI/LO; one bit per cycle.
// Optional signed support is enabled by defining MULDIV_SIGNED_EN.
module mul_div_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_count;
    logic               r_op_div;
    logic               r_divzero;
    logic [WIDTH-1:0]   r_operand;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_shreg;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    logic               w_accept;
    logic               w_is_divzero;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_step_acc;
    logic [WIDTH-1:0]   w_step_shreg;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    assign w_accept     = (r_state == S_IDLE) && start;
    assign w_is_divzero = (op[0] == OP_DIV) && (op_b == {WIDTH{1'b0}});

    muldiv_step #(
        .WIDTH     (WIDTH)
    ) u_step (
        .i_op_div  (r_op_div),
        .i_acc     (r_acc),
        .i_shreg   (r_shreg),
        .i_operand (r_operand),
        .o_acc     (w_step_acc),
        .o_shreg   (w_step_shreg)
    );

`ifdef MULDIV_SIGNED_EN
    logic               w_neg_a;
    logic               w_neg_b;
    logic               r_neg_res;
    logic               r_neg_rem;
    logic [2*WIDTH-1:0] w_prod_neg;

    assign w_neg_a = op[OP_SIGNED] & op_a[WIDTH-1];
    assign w_neg_b = op[OP_SIGNED] & op_b[WIDTH-1];
    assign w_abs_a = w_neg_a ? (~op_a + WIDTH'(1)) : op_a;
    assign w_abs_b = w_neg_b ? (~op_b + WIDTH'(1)) : op_b;
    assign w_prod_neg = ~{r_acc, r_shreg} + (2*WIDTH)'(1);

    // Sign fixup flags captured with the operands
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
        end else if (w_accept) begin
            r_neg_res <= w_neg_a ^ w_neg_b;
            r_neg_rem <= w_neg_a;
        end else begin
            r_neg_res <= r_neg_res;
            r_neg_rem <= r_neg_rem;
        end
    end

    // Final result with sign fixup; remainder follows the dividend's sign
    always_comb begin
        w_res_hi = r_acc;
        w_res_lo = r_shreg;
        if (r_divzero) begin
            w_res_hi = r_shreg;
            w_res_lo = {WIDTH{1'b1}};
        end else if (r_op_div == OP_MUL) begin
            if (r_neg_res) begin
                w_res_hi = w_prod_neg[2*WIDTH-1:WIDTH];
                w_res_lo = w_prod_neg[WIDTH-1:0];
            end else begin
                w_res_hi = r_acc;
                w_res_lo = r_shreg;
            end
        end else begin
            w_res_lo = r_neg_res ? (~r_shreg + WIDTH'(1)) : r_shreg;
            w_res_hi = r_neg_rem ? (~r_acc + WIDTH'(1)) : r_acc;
        end
    end
`else
    logic w_unused_sign;

    assign w_unused_sign = op[OP_SIGNED];
    assign w_abs_a       = op_a;
    assign w_abs_b       = op_b;

    // Final result; divide-by-zero returns all-ones quotient and the dividend as remainder
    always_comb begin
        w_res_hi = r_acc;
        w_res_lo = r_shreg;
        if (r_divzero) begin
            w_res_hi = r_shreg;
            w_res_lo = {WIDTH{1'b1}};
        end else begin
            w_res_hi = r_acc;
            w_res_lo = r_shreg;
        end
    end
`endif

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = w_is_divzero ? S_DONE : S_BUSY;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_BUSY: begin
                if (r_count == CNT_W'(WIDTH - 1)) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_BUSY;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Operand capture, iteration and HI/LO result registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count   <= {CNT_W{1'b0}};
            r_op_div  <= 1'b0;
            r_divzero <= 1'b0;
            r_operand <= {WIDTH{1'b0}};
            r_acc     <= {WIDTH{1'b0}};
            r_shreg   <= {WIDTH{1'b0}};
            r_hi      <= {WIDTH{1'b0}};
            r_lo      <= {WIDTH{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_count   <= {CNT_W{1'b0}};
                        r_acc     <= {WIDTH{1'b0}};
                        r_op_div  <= op[0];
                        r_divzero <= w_is_divzero;
                        if (op[0] == OP_DIV) begin
                            // Divide-by-zero keeps the raw dividend for the remainder output
                            r_shreg   <= w_is_divzero ? op_a : w_abs_a;
                            r_operand <= w_abs_b;
                        end else begin
                            r_shreg   <= w_abs_b;
                            r_operand <= w_abs_a;
                        end
                    end
                end
                S_BUSY: begin
                    r_acc   <= w_step_acc;
                    r_shreg <= w_step_shreg;
                    r_count <= r_count + CNT_W'(1);
                end
                S_DONE: begin
                    r_hi <= w_res_hi;
                    r_lo <= w_res_lo;
                end
                default: begin
                    r_count <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Registered status: busy covers the done cycle, start is only sampled in IDLE
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (r_state != S_IDLE);
            r_done <= (r_state == S_DONE);
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign hi_out = r_hi;
    assign lo_out = r_lo;

endmodule
